regfile_write_bank: RTL and testbench

- Write side of the CPU register file: a 5:32 write-address decoder driving 32 x 64-bit registers, with register 31 (XZR) hardwired to zero.
- Exports the full register array flattened, so the read-port mux trees (built elsewhere from mux4_1/mux2_1) select from it.
- Also registers the last completed write (address, data, valid) for the pipeline's write-back forwarding check.
- Sits between the WB stage and the register-file read muxes.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_write_bank_if.sv | 29 ++
 rtl/regfile_write_bank_decoder.sv | 60 ++++++
 rtl/regfile_write_bank.sv | 71 +++++++
 tb/tb_regfile_write_bank.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizes and flat-bus slicing helper for the register file
//
// Purpose:
//   Register-file geometry used by the write bank, its bus interface and
//   the read-side mux trees that select from regs_flat.
//   reg_slice() extracts register idx from the flattened array. Register i
//   occupies bits [i*WIDTH +: WIDTH].
package regfile_pkg;

   localparam int WIDTH    = 64;
   localparam int NREGS    = 32;
   localparam int ADDR_W   = 5;
   localparam int ZERO_REG = 31;

   function automatic logic [WIDTH-1:0] reg_slice(input logic [NREGS*WIDTH-1:0] flat,
                                                  input int                      idx);
      return flat[idx*WIDTH +: WIDTH];
   endfunction

endpackage

// File: rtl/regfile_write_bank_if.sv
// rtl/regfile_write_bank_if.sv - write-back port and last-write capture bundle
//
// Purpose:
//   Groups the WB-stage write request with the registered last-write record
//   that the forwarding logic consumes.
// Signals:
//   wr_en, wr_addr, wr_data                    : write request (driven by master)
//   last_wr_valid, last_wr_addr, last_wr_data  : last completed write (driven by slave)
interface regfile_write_bank_if;
   import regfile_pkg::*;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              last_wr_valid;
   logic [ADDR_W-1:0] last_wr_addr;
   logic [WIDTH-1:0]  last_wr_data;

   modport master (
      output wr_en, wr_addr, wr_data,
      input  last_wr_valid, last_wr_addr, last_wr_data
   );

   modport slave (
      input  wr_en, wr_addr, wr_data,
      output last_wr_valid, last_wr_addr, last_wr_data
   );

endinterface

// File: rtl/regfile_write_bank_decoder.sv
// rtl/regfile_write_bank_decoder.sv - structural 5:32 write-address decoder
//
// Purpose:
//   decoder_5_32 turns an enable and a 5-bit address into a 32-bit one-hot.
//   It is built from a 2:4 decoder on addr[4:3] and a 3:8 decoder on addr[2:0].
//   Output bit (hi*8 + lo) is the AND of the two partial decodes.
//   The enable is applied only to the 2:4 stage, so every output is forced
//   low while en=0, whatever the address bits carry.
// Ports (decoder_5_32):
//   en      in  1   write enable
//   addr    in  5   register index
//   onehot  out 32  one-hot decode, all zero when en=0

module dec2_4 (
   input  logic       en,
   input  logic [1:0] a,
   output logic [3:0] y
);
   assign y[0] = en & ~a[1] & ~a[0];
   assign y[1] = en & ~a[1] &  a[0];
   assign y[2] = en &  a[1] & ~a[0];
   assign y[3] = en &  a[1] &  a[0];
endmodule

module dec3_8 (
   input  logic       en,
   input  logic [2:0] a,
   output logic [7:0] y
);
   for (genvar j = 0; j < 8; j++) begin : g_out
      assign y[j] = en & (a == 3'(j));
   end
endmodule

module decoder_5_32 (
   input  logic        en,
   input  logic [4:0]  addr,
   output logic [31:0] onehot
);
   logic [3:0] hi;
   logic [7:0] lo;

   dec2_4 u_hi (
      .en (en),
      .a  (addr[4:3]),
      .y  (hi)
   );

   dec3_8 u_lo (
      .en (1'b1),
      .a  (addr[2:0]),
      .y  (lo)
   );

   for (genvar h = 0; h < 4; h++) begin : g_hi
      for (genvar l = 0; l < 8; l++) begin : g_lo
         assign onehot[h*8 + l] = hi[h] & lo[l];
      end
   end
endmodule

// File: rtl/regfile_write_bank.sv
// rtl/regfile_write_bank.sv - register-file write side with hardwired-zero XZR
//
// Purpose:
//   Holds 32 x 64-bit registers written from the WB stage through a one-hot
//   decode. Register ZERO_REG has no storage and always reads 0.
//   The bank also records the last completed non-zero-register write. The
//   read side uses that record to decide on forwarding.
// Ports:
//   clk            in   1            posedge clock
//   reset          in   1            synchronous, active-high; beats any write
//   wbus           slave            wr_en/wr_addr/wr_data in, last_wr_* out
//   regs_flat      out  NREGS*WIDTH  register i at [i*WIDTH +: WIDTH]
//   wr_dec_onehot  out  NREGS        combinational wr_en-gated address decode
module regfile_write_bank
   import regfile_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   regfile_write_bank_if.slave      wbus,
   output logic [NREGS*WIDTH-1:0]   regs_flat,
   output logic [NREGS-1:0]         wr_dec_onehot
);

   logic wr_hit;

   decoder_5_32 u_dec (
      .en     (wbus.wr_en),
      .addr   (wbus.wr_addr),
      .onehot (wr_dec_onehot)
   );

   // The zero register gets no flop at all. Its enable term (i != ZERO_REG)
   // is resolved at elaboration time, so a write to it is simply absorbed.
   for (genvar i = 0; i < NREGS; i++) begin : g_reg
      if (i == ZERO_REG) begin : g_zero
         assign regs_flat[i*WIDTH +: WIDTH] = '0;
      end else begin : g_dff
         logic [WIDTH-1:0] q;

         always_ff @(posedge clk) begin
            if (reset) begin
               q <= '0;
            end else if (wr_dec_onehot[i]) begin
               q <= wbus.wr_data;
            end
         end

         assign regs_flat[i*WIDTH +: WIDTH] = q;
      end
   end

   // The valid flag tracks every cycle. The address and data fields keep
   // the last real write, so they stay meaningful after a XZR write or an
   // idle cycle.
   assign wr_hit = wbus.wr_en & (wbus.wr_addr != ADDR_W'(ZERO_REG));

   always_ff @(posedge clk) begin
      if (reset) begin
         wbus.last_wr_valid <= 1'b0;
         wbus.last_wr_addr  <= '0;
         wbus.last_wr_data  <= '0;
      end else begin
         wbus.last_wr_valid <= wr_hit;
         if (wr_hit) begin
            wbus.last_wr_addr <= wbus.wr_addr;
            wbus.last_wr_data <= wbus.wr_data;
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_bank.sv
// tb/tb_regfile_write_bank.sv - randomized self-checking bench for regfile_write_bank
module tb_regfile_write_bank;
   import regfile_pkg::*;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NREGS*WIDTH-1:0] regs_flat;
   logic [NREGS-1:0]       wr_dec_onehot;

   always #5 clk = ~clk;

   regfile_write_bank_if bus ();

   regfile_write_bank dut (
      .clk           (clk),
      .reset         (reset),
      .wbus          (bus),
      .regs_flat     (regs_flat),
      .wr_dec_onehot (wr_dec_onehot)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Reference state: an array of register values plus the last-write record.
   logic [WIDTH-1:0]  m_regs [NREGS];
   logic              m_valid;
   logic [ADDR_W-1:0] m_addr;
   logic [WIDTH-1:0]  m_data;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         foreach (m_regs[k]) m_regs[k] <= '0;
         m_valid <= 1'b0;
         m_addr  <= '0;
         m_data  <= '0;
      end else begin
         m_valid <= bus.wr_en && (int'(bus.wr_addr) != ZERO_REG);
         if (bus.wr_en && (int'(bus.wr_addr) != ZERO_REG)) begin
            m_regs[bus.wr_addr] <= bus.wr_data;
            m_addr              <= bus.wr_addr;
            m_data              <= bus.wr_data;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic [NREGS-1:0] exp_oh;
         exp_oh = bus.wr_en ? (NREGS'(1) << bus.wr_addr) : '0;
         for (int i = 0; i < NREGS; i++)
            chk($sformatf("model_reg%0d", i), reg_slice(regs_flat, i), m_regs[i]);
         chk("model_last_valid", WIDTH'(bus.last_wr_valid), WIDTH'(m_valid));
         chk("model_last_addr", WIDTH'(bus.last_wr_addr), WIDTH'(m_addr));
         chk("model_last_data", bus.last_wr_data, m_data);
         chk("model_onehot", WIDTH'(wr_dec_onehot), WIDTH'(exp_oh));
      end
   end

   task automatic drive(input logic r, input logic e, input int a, input logic [WIDTH-1:0] d);
      reset       = r;
      bus.wr_en   = e;
      bus.wr_addr = ADDR_W'(a);
      bus.wr_data = d;
   endtask

   task automatic cyc(input logic r, input logic e, input int a, input logic [WIDTH-1:0] d);
      drive(r, e, a, d);
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1'b1, 1'b0, 0, '0);
      @(posedge clk);
      #1;
      chk_en = 1'b1;

      // Load every register with all ones, then reset for one cycle.
      for (int i = 0; i < NREGS; i++) cyc(1'b0, 1'b1, i, '1);
      cyc(1'b1, 1'b0, 0, '0);
      for (int i = 0; i < NREGS; i++)
         chk($sformatf("pin_reset_reg%0d", i), reg_slice(regs_flat, i), '0);
      chk("pin_reset_valid", WIDTH'(bus.last_wr_valid), '0);

      // Write X5.
      cyc(1'b0, 1'b1, 5, 64'h0123_4567_89AB_CDEF);
      chk("pin_x5", reg_slice(regs_flat, 5), 64'h0123_4567_89AB_CDEF);
      chk("pin_x4_zero", reg_slice(regs_flat, 4), '0);
      chk("pin_x6_zero", reg_slice(regs_flat, 6), '0);
      chk("pin_x5_valid", WIDTH'(bus.last_wr_valid), 64'd1);
      chk("pin_x5_addr", WIDTH'(bus.last_wr_addr), 64'd5);

      // Walking sweep: reg i <= i+1.
      for (int i = 0; i < NREGS; i++) begin
         drive(1'b0, 1'b1, i, WIDTH'(i + 1));
         #2;
         chk($sformatf("pin_walk_onehot%0d", i), WIDTH'(wr_dec_onehot), WIDTH'(64'd1 << i));
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < NREGS - 1; i++)
         chk($sformatf("pin_walk_reg%0d", i), reg_slice(regs_flat, i), WIDTH'(i + 1));
      chk("pin_walk_reg31", reg_slice(regs_flat, 31), '0);

      // Write to XZR is absorbed; last-write fields keep X30 <= 31.
      cyc(1'b0, 1'b1, 31, 64'hDEAD);
      chk("pin_xzr_reg", reg_slice(regs_flat, 31), '0);
      chk("pin_xzr_valid", WIDTH'(bus.last_wr_valid), '0);
      chk("pin_xzr_addr", WIDTH'(bus.last_wr_addr), 64'd30);
      chk("pin_xzr_data", bus.last_wr_data, 64'd31);

      // Idle cycles with a live-looking address.
      drive(1'b0, 1'b0, 7, 64'h55);
      for (int k = 0; k < 3; k++) begin
         #2;
         chk("pin_idle_onehot", WIDTH'(wr_dec_onehot), '0);
         @(posedge clk);
         #1;
         chk("pin_idle_valid", WIDTH'(bus.last_wr_valid), '0);
         chk("pin_idle_x7", reg_slice(regs_flat, 7), 64'd8);
      end

      // A write coincident with reset is dropped.
      cyc(1'b1, 1'b1, 3, 64'h77);
      chk("pin_rstwr_x3", reg_slice(regs_flat, 3), '0);
      cyc(1'b0, 1'b1, 3, 64'h77);
      chk("pin_after_x3", reg_slice(regs_flat, 3), 64'h77);

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         logic             r;
         logic             e;
         int               a;
         logic [WIDTH-1:0] d;
         r = ($urandom_range(0, 39) == 0);
         e = ($urandom_range(0, 3) != 0);
         a = ($urandom_range(0, 7) == 0) ? ZERO_REG : int'($urandom_range(0, NREGS - 1));
         d = {$urandom, $urandom};
         cyc(r, e, a, d);
      end

      drive(1'b0, 1'b0, 0, '0);
      @(negedge clk);
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
